// File: rtl/l1a_ring_scheduler_if.sv
// Bundle of trigger, ring-pointer and readout-FSM signals around the L1A ring scheduler.
// The slave modport is the scheduler. The master modport is whoever drives the trigger
// and the readout FSM controls.
interface l1a_ring_scheduler_if #(
  parameter int ADDR_W = 7
);
  // Inputs: trigger and ring write pointer
  logic              L1A;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [ADDR_W-1:0] L1A_LATENCY;

  // Inputs: readout FSM controls
  logic              LD_ADDR;
  logic              RD;
  logic              NXT_L1A;
  logic              CLR_ERR;

  // Outputs: scheduler state
  logic [ADDR_W-1:0] RD_PTR;
  logic [11:0]       HEAD_L1A_NUM;
  logic              L1A_BUF_MT;
  logic              L1A_BUF_FULL;
  logic              RING_AMT;
  logic [11:0]       L1A_CNT;
  logic [7:0]        DROP_CNT;
  logic              L1A_OVFL;
  logic              POP_ERR;

  modport master (
    output L1A, WR_ADDR, L1A_LATENCY, LD_ADDR, RD, NXT_L1A, CLR_ERR,
    input  RD_PTR, HEAD_L1A_NUM, L1A_BUF_MT, L1A_BUF_FULL, RING_AMT,
           L1A_CNT, DROP_CNT, L1A_OVFL, POP_ERR
  );

  modport slave (
    input  L1A, WR_ADDR, L1A_LATENCY, LD_ADDR, RD, NXT_L1A, CLR_ERR,
    output RD_PTR, HEAD_L1A_NUM, L1A_BUF_MT, L1A_BUF_FULL, RING_AMT,
           L1A_CNT, DROP_CNT, L1A_OVFL, POP_ERR
  );
endinterface

// File: rtl/l1a_ring_scheduler.sv
// L1A ring scheduler.
// Every L1A queues the event start address (write pointer minus trigger latency) together
// with the L1A number in a small first-word-fall-through FIFO. The queue head is served to
// the readout FSM. The block owns the ring read pointer and produces the readout FSM's
// L1A_BUF_MT and RING_AMT inputs.
module l1a_ring_scheduler #(
  parameter int ADDR_W      = 7,
  parameter int QDEPTH_LOG2 = 3,
  parameter int AMT_THRESH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  l1a_ring_scheduler_if.slave   bus
);

  localparam int                 QDEPTH     = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0] CNT_FULL = (QDEPTH_LOG2 + 1)'(QDEPTH);
  localparam logic [QDEPTH_LOG2:0] CNT_ONE  = (QDEPTH_LOG2 + 1)'(1);
  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE = QDEPTH_LOG2'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  AMT_LIMIT  = ADDR_W'(AMT_THRESH);

  // Queue storage. The queue is small, so the head is read combinationally (FWFT).
  logic [ADDR_W-1:0] addr_mem [QDEPTH];
  logic [11:0]       num_mem  [QDEPTH];

  logic [QDEPTH_LOG2-1:0] q_wr_ptr_reg, q_rd_ptr_reg, q_rd_ptr_next;
  logic [QDEPTH_LOG2:0]   q_cnt_reg, q_cnt_next;

  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [11:0]       head_num_reg, head_num_next;
  logic              buf_mt_reg, buf_full_reg, ring_amt_reg;
  logic [11:0]       l1a_cnt_reg;
  logic [7:0]        drop_cnt_reg;
  logic              ovfl_reg, pop_err_reg;

  logic              q_not_empty, q_full;
  logic              pop_ok, push_ok, drop_evt, pop_err_evt;
  logic [ADDR_W-1:0] push_addr, head_addr, ring_dist;

  assign q_not_empty = (q_cnt_reg != '0);
  assign q_full      = (q_cnt_reg == CNT_FULL);

  // A pop frees a slot in the same cycle, so a push into a full queue that is popping is not a drop.
  assign pop_ok      = bus.NXT_L1A && q_not_empty;
  assign pop_err_evt = bus.NXT_L1A && !q_not_empty;
  assign push_ok     = bus.L1A && (!q_full || pop_ok);
  assign drop_evt    = bus.L1A && !push_ok;

  assign push_addr   = bus.WR_ADDR - bus.L1A_LATENCY;
  assign head_addr   = q_not_empty ? addr_mem[q_rd_ptr_reg] : '0;
  assign ring_dist   = bus.WR_ADDR - rd_ptr_reg;

  // Next queue count, next read pointer and the number that will sit at the head next cycle.
  always_comb begin
    q_cnt_next    = q_cnt_reg;
    q_rd_ptr_next = q_rd_ptr_reg;
    head_num_next = head_num_reg;
    if (push_ok && !pop_ok) begin
      q_cnt_next = q_cnt_reg + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      q_cnt_next = q_cnt_reg - CNT_ONE;
    end
    if (pop_ok) begin
      q_rd_ptr_next = q_rd_ptr_reg + PTR_ONE;
    end
    // The slot about to be written has not been committed to memory yet, so forward it.
    if (q_cnt_next != '0) begin
      if (push_ok && (q_rd_ptr_next == q_wr_ptr_reg)) begin
        head_num_next = l1a_cnt_reg;
      end else begin
        head_num_next = num_mem[q_rd_ptr_next];
      end
    end
  end

  // Queue storage write. The contents need no reset because the count gates every read.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      addr_mem[q_wr_ptr_reg] <= push_addr;
      num_mem[q_wr_ptr_reg]  <= l1a_cnt_reg;
    end
  end

  // Queue pointers, occupancy and the registered empty/full/head outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_wr_ptr_reg <= '0;
      q_rd_ptr_reg <= '0;
      q_cnt_reg    <= '0;
      buf_mt_reg   <= 1'b1;
      buf_full_reg <= 1'b0;
      head_num_reg <= '0;
    end else begin
      if (push_ok) begin
        q_wr_ptr_reg <= q_wr_ptr_reg + PTR_ONE;
      end
      q_rd_ptr_reg <= q_rd_ptr_next;
      q_cnt_reg    <= q_cnt_next;
      buf_mt_reg   <= (q_cnt_next == '0);
      buf_full_reg <= (q_cnt_next == CNT_FULL);
      head_num_reg <= head_num_next;
    end
  end

  // Ring read pointer. A load from the queue head takes priority over a word advance.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_reg <= '0;
    end else if (bus.LD_ADDR) begin
      rd_ptr_reg <= head_addr;
    end else if (bus.RD) begin
      rd_ptr_reg <= rd_ptr_reg + ADDR_ONE;
    end
  end

  // Ring almost-empty flag: the unread distance from the read to the write pointer is small.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ring_amt_reg <= 1'b0;
    end else begin
      ring_amt_reg <= (ring_dist <= AMT_LIMIT);
    end
  end

  // Trigger counter, drop counter and sticky error flags. A new event wins over a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      l1a_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      ovfl_reg     <= 1'b0;
      pop_err_reg  <= 1'b0;
    end else begin
      if (bus.L1A) begin
        l1a_cnt_reg <= l1a_cnt_reg + 12'd1;
      end
      if (bus.CLR_ERR) begin
        drop_cnt_reg <= drop_evt ? 8'd1 : 8'd0;
      end else if (drop_evt && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
      if (drop_evt) begin
        ovfl_reg <= 1'b1;
      end else if (bus.CLR_ERR) begin
        ovfl_reg <= 1'b0;
      end
      if (pop_err_evt) begin
        pop_err_reg <= 1'b1;
      end else if (bus.CLR_ERR) begin
        pop_err_reg <= 1'b0;
      end
    end
  end

  assign bus.RD_PTR       = rd_ptr_reg;
  assign bus.HEAD_L1A_NUM = head_num_reg;
  assign bus.L1A_BUF_MT   = buf_mt_reg;
  assign bus.L1A_BUF_FULL = buf_full_reg;
  assign bus.RING_AMT     = ring_amt_reg;
  assign bus.L1A_CNT      = l1a_cnt_reg;
  assign bus.DROP_CNT     = drop_cnt_reg;
  assign bus.L1A_OVFL     = ovfl_reg;
  assign bus.POP_ERR      = pop_err_reg;

endmodule

// File: tb/tb_l1a_ring_scheduler.sv
// Directed bench for the L1A ring scheduler. Queued events are tracked in a scoreboard
// queue: an entry is pushed when an accepted L1A is driven and popped when the readout
// side consumes it.
module tb_l1a_ring_scheduler;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  l1a_ring_scheduler_if #(.ADDR_W(7)) bus();

  l1a_ring_scheduler #(.ADDR_W(7), .QDEPTH_LOG2(3), .AMT_THRESH(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0]  addr;
    logic [11:0] num;
  } ent_t;

  ent_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [11:0] exp_cnt  = '0;
  logic [7:0]  exp_drop = '0;
  logic [6:0]  exp_rd   = '0;
  ent_t        ent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs set before this call are sampled on the edge, outputs settle 1ns after.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic l1a_push(input logic [6:0] wr, input logic [6:0] lat);
    bus.WR_ADDR     = wr;
    bus.L1A_LATENCY = lat;
    bus.L1A         = 1'b1;
    step();
    bus.L1A = 1'b0;
    if (sb.size() < 8) begin
      ent.addr = wr - lat;
      ent.num  = exp_cnt;
      sb.push_back(ent);
    end else begin
      exp_drop = (exp_drop == 8'hFF) ? exp_drop : exp_drop + 8'd1;
    end
    exp_cnt = exp_cnt + 12'd1;
  endtask

  // Consume the scoreboard head: check its number, load RD_PTR from it, then pop it.
  task automatic serve(input string tag);
    ent = sb[0];
    chk({tag, "_head_num"}, 32'(bus.HEAD_L1A_NUM), 32'(ent.num));
    bus.LD_ADDR = 1'b1;
    step();
    bus.LD_ADDR = 1'b0;
    exp_rd = ent.addr;
    chk({tag, "_rd_ptr"}, 32'(bus.RD_PTR), 32'(exp_rd));
    bus.NXT_L1A = 1'b1;
    step();
    bus.NXT_L1A = 1'b0;
    void'(sb.pop_front());
    chk({tag, "_mt"}, 32'(bus.L1A_BUF_MT), 32'(sb.size() == 0));
    $display("[TB] served L1A %0d addr %0d, %0d left", ent.num, ent.addr, sb.size());
  endtask

  initial begin
    bus.L1A = 0; bus.WR_ADDR = 0; bus.L1A_LATENCY = 0;
    bus.LD_ADDR = 0; bus.RD = 0; bus.NXT_L1A = 0; bus.CLR_ERR = 0;

    // Reset values
    step(); step();
    chk("rst_mt",   32'(bus.L1A_BUF_MT),   1);
    chk("rst_full", 32'(bus.L1A_BUF_FULL), 0);
    chk("rst_rd",   32'(bus.RD_PTR),       0);
    chk("rst_cnt",  32'(bus.L1A_CNT),      0);
    chk("rst_amt",  32'(bus.RING_AMT),     0);
    chk("rst_head", 32'(bus.HEAD_L1A_NUM), 0);
    RST_N = 1'b1;
    step();

    // 1) Basic push and load
    l1a_push(7'd40, 7'd24);
    chk("t1_mt",  32'(bus.L1A_BUF_MT), 0);
    chk("t1_cnt", 32'(bus.L1A_CNT), 32'(exp_cnt));
    serve("t1");
    chk("t1_head_hold", 32'(bus.HEAD_L1A_NUM), 0);

    // 2) Start address wraps below zero; RD_PTR wraps at the ring top
    l1a_push(7'd5, 7'd24);
    serve("t2");
    bus.RD = 1'b1;
    repeat (20) step();
    bus.RD = 1'b0;
    exp_rd = exp_rd + 7'd20;
    chk("t2_rd_wrap", 32'(bus.RD_PTR), 32'(exp_rd));
    chk("t2_rd_abs",  32'(bus.RD_PTR), 1);

    // 3) Fill, overflow, then push+pop while full
    for (int i = 0; i < 8; i++) l1a_push(7'(i * 10), 7'd3);
    chk("t3_full8", 32'(bus.L1A_BUF_FULL), 1);
    chk("t3_ovfl0", 32'(bus.L1A_OVFL), 0);
    l1a_push(7'd100, 7'd3);
    chk("t3_full9", 32'(bus.L1A_BUF_FULL), 1);
    chk("t3_ovfl",  32'(bus.L1A_OVFL), 1);
    chk("t3_drop",  32'(bus.DROP_CNT), 32'(exp_drop));
    chk("t3_cnt",   32'(bus.L1A_CNT), 32'(exp_cnt));
    chk("t3_head",  32'(bus.HEAD_L1A_NUM), 32'(sb[0].num));
    bus.WR_ADDR = 7'd77; bus.L1A_LATENCY = 7'd7;
    bus.L1A = 1'b1; bus.NXT_L1A = 1'b1;
    step();
    bus.L1A = 1'b0; bus.NXT_L1A = 1'b0;
    void'(sb.pop_front());
    ent.addr = 7'd70; ent.num = exp_cnt;
    sb.push_back(ent);
    exp_cnt = exp_cnt + 12'd1;
    chk("t3_pp_full", 32'(bus.L1A_BUF_FULL), 1);
    chk("t3_pp_drop", 32'(bus.DROP_CNT), 32'(exp_drop));
    chk("t3_pp_head", 32'(bus.HEAD_L1A_NUM), 32'(sb[0].num));
    while (sb.size() > 0) serve("t3_drain");
    chk("t3_notfull", 32'(bus.L1A_BUF_FULL), 0);

    // 4) Pop on empty, clear, and error winning over a same-cycle clear
    bus.NXT_L1A = 1'b1;
    step();
    bus.NXT_L1A = 1'b0;
    chk("t4_poperr", 32'(bus.POP_ERR), 1);
    chk("t4_mt",     32'(bus.L1A_BUF_MT), 1);
    bus.CLR_ERR = 1'b1;
    step();
    bus.CLR_ERR = 1'b0;
    exp_drop = '0;
    chk("t4_clr_pop",  32'(bus.POP_ERR), 0);
    chk("t4_clr_drop", 32'(bus.DROP_CNT), 0);
    chk("t4_clr_ovfl", 32'(bus.L1A_OVFL), 0);
    bus.CLR_ERR = 1'b1; bus.NXT_L1A = 1'b1;
    step();
    bus.CLR_ERR = 1'b0; bus.NXT_L1A = 1'b0;
    chk("t4_err_wins", 32'(bus.POP_ERR), 1);
    bus.CLR_ERR = 1'b1;
    step();
    bus.CLR_ERR = 1'b0;

    // 5) Ring almost-empty threshold
    l1a_push(7'd50, 7'd0);
    bus.LD_ADDR = 1'b1;
    step();
    bus.LD_ADDR = 1'b0;
    chk("t5_rd", 32'(bus.RD_PTR), 50);
    bus.WR_ADDR = 7'd52;
    step();
    chk("t5_amt_at", 32'(bus.RING_AMT), 1);
    bus.WR_ADDR = 7'd53;
    step();
    chk("t5_amt_above", 32'(bus.RING_AMT), 0);
    bus.NXT_L1A = 1'b1;
    step();
    bus.NXT_L1A = 1'b0;
    void'(sb.pop_front());

    // 6) Asynchronous reset in the middle of a readout
    for (int i = 0; i < 3; i++) l1a_push(7'(60 + i), 7'd10);
    bus.LD_ADDR = 1'b1;
    step();
    bus.LD_ADDR = 1'b0;
    bus.RD = 1'b1;
    step();
    bus.RD = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_mt",   32'(bus.L1A_BUF_MT), 1);
    chk("t6_rd",   32'(bus.RD_PTR), 0);
    chk("t6_cnt",  32'(bus.L1A_CNT), 0);
    chk("t6_head", 32'(bus.HEAD_L1A_NUM), 0);
    sb.delete();
    exp_cnt = '0;
    exp_drop = '0;
    step();
    RST_N = 1'b1;
    step();
    l1a_push(7'd40, 7'd24);
    serve("t6_post");
    chk("t6_post_cnt", 32'(bus.L1A_CNT), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
